wshb_sdram_arbiter: RTL and testbench

// - Shares the single SDRAM Wishbone slave (wshb_if_sdram) between two Wishbone masters.
// - M0 is the video stream reader (latency-critical); M1 is the frame writer / pattern generator.
// - Sits in Top between the masters and hw_support's SDRAM port, in the sys_clk domain.
// - Round-robin grant at Wishbone-cycle granularity; a grant is held for the whole cyc burst.

---
 rtl/wshb_sdram_arbiter.sv | 155 +++++++++++++++
 tb/tb_wshb_sdram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_sdram_arbiter.sv
// wshb_sdram_arbiter
//   Shares one SDRAM Wishbone slave between two Wishbone masters.
//   M0 is the video stream reader, M1 the frame writer / pattern generator.
//   Round-robin arbitration at Wishbone-cycle granularity: once a master is
//   granted it keeps the slave until it drops cyc, so bursts are never split.
//
// Ports
//   sys_clk, sys_rst            clock, asynchronous active-high reset
//   m0_* / m1_*                 master request inputs (cyc, stb, we, adr,
//                               dat_ms, sel, cti, bte) and response outputs
//                               (ack, err, rty gated by grant; dat_sm broadcast)
//   s_*                         slave request outputs muxed from the granted
//                               master, slave response inputs
//   gnt                         one-hot grant: 01=M0, 10=M1, 00=none
module wshb_sdram_arbiter #(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  // master 0
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADR_W-1:0]      m0_adr,
  input  logic [DATA_W-1:0]     m0_dat_ms,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [2:0]            m0_cti,
  input  logic [1:0]            m0_bte,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic                  m0_rty,
  output logic [DATA_W-1:0]     m0_dat_sm,
  // master 1
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADR_W-1:0]      m1_adr,
  input  logic [DATA_W-1:0]     m1_dat_ms,
  input  logic [DATA_W/8-1:0]   m1_sel,
  input  logic [2:0]            m1_cti,
  input  logic [1:0]            m1_bte,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  m1_rty,
  output logic [DATA_W-1:0]     m1_dat_sm,
  // slave
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADR_W-1:0]      s_adr,
  output logic [DATA_W-1:0]     s_dat_ms,
  output logic [DATA_W/8-1:0]   s_sel,
  output logic [2:0]            s_cti,
  output logic [1:0]            s_bte,
  input  logic                  s_ack,
  input  logic                  s_err,
  input  logic                  s_rty,
  input  logic [DATA_W-1:0]     s_dat_sm,
  // grant
  output logic [1:0]            gnt
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 0 = M0 served last, 1 = M1

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;               // M0 wins the first tie
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc)      state_d = GNT1;
      end
      // The cycle in which the owner drops cyc is the handover cycle: the
      // slave sees cyc low there, and the waiting master owns the next one.
      GNT0: begin
        if (!m0_cyc) begin
          last_gnt_d = 1'b0;
          state_d    = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          last_gnt_d = 1'b1;
          state_d    = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic g0, g1;
  assign g0  = (state_q == GNT0);
  assign g1  = (state_q == GNT1);
  assign gnt = state_q;

  // Request mux; everything is zero while nobody owns the slave.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    if (g0) begin
      s_cyc    = m0_cyc;
      s_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_dat_ms = m0_dat_ms;
      s_sel    = m0_sel;
      s_cti    = m0_cti;
      s_bte    = m0_bte;
    end else if (g1) begin
      s_cyc    = m1_cyc;
      s_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_ms = m1_dat_ms;
      s_sel    = m1_sel;
      s_cti    = m1_cti;
      s_bte    = m1_bte;
    end
  end

  // Responses only reach the owner; read data is broadcast.
  assign m0_ack    = s_ack & g0;
  assign m0_err    = s_err & g0;
  assign m0_rty    = s_rty & g0;
  assign m1_ack    = s_ack & g1;
  assign m1_err    = s_err & g1;
  assign m1_rty    = s_rty & g1;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// tb_wshb_sdram_arbiter
//   Directed bench for the two-master SDRAM Wishbone arbiter: reset,
//   single-master writes, tie break, round-robin bursts, stalled hold and
//   mid-burst reset.
module tb_wshb_sdram_arbiter;
  localparam int ADR_W  = 32;
  localparam int DATA_W = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [ADR_W-1:0]  m0_adr, m1_adr, s_adr;
  logic [DATA_W-1:0] m0_dat_ms, m1_dat_ms, s_dat_ms;
  logic [3:0]        m0_sel, m1_sel, s_sel;
  logic [2:0]        m0_cti, m1_cti, s_cti;
  logic [1:0]        m0_bte, m1_bte, s_bte;
  logic              m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [DATA_W-1:0] m0_dat_sm, m1_dat_sm;
  logic              s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [DATA_W-1:0] s_dat_sm;
  logic [1:0]        gnt;
  logic              ack_en;

  always #5 sys_clk = ~sys_clk;

  // Zero-wait slave that acks any strobe while ack_en is set.
  assign s_ack    = s_cyc & s_stb & ack_en;
  assign s_dat_sm = 32'hA5A5_1234;

  wshb_sdram_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave-side log of accepted beats plus an s_cyc trace, taken at negedges.
  typedef struct packed {
    logic [1:0]  g;
    logic [31:0] adr;
    logic        we;
    logic [2:0]  cti;
  } beat_t;

  beat_t log_q[$];
  bit    trace_q[$];
  int    ack0_cnt, ack1_cnt;

  always @(negedge sys_clk) begin
    beat_t b;
    if (s_cyc && s_stb && s_ack) begin
      b.g = gnt; b.adr = s_adr; b.we = s_we; b.cti = s_cti;
      log_q.push_back(b);
    end
    trace_q.push_back(s_cyc);
    if (m0_ack) ack0_cnt++;
    if (m1_ack) ack1_cnt++;
  end

  // Segments of consecutive beats under the same grant.
  logic [1:0]  seg_g[$];
  int          seg_n[$];
  logic [31:0] seg_a0[$];

  task automatic build_segs();
    seg_g.delete(); seg_n.delete(); seg_a0.delete();
    foreach (log_q[i]) begin
      if (i == 0 || log_q[i].g != log_q[i-1].g) begin
        seg_g.push_back(log_q[i].g);
        seg_n.push_back(1);
        seg_a0.push_back(log_q[i].adr);
      end else begin
        seg_n[seg_n.size()-1]++;
      end
    end
  endtask

  task automatic drive(input int m, input logic cyc, input logic [31:0] adr,
                       input logic we, input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr;
      m0_dat_ms = ~adr; m0_sel = 4'hF; m0_cti = cti; m0_bte = 2'b00;
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr;
      m1_dat_ms = ~adr; m1_sel = 4'hF; m1_cti = cti; m1_bte = 2'b00;
    end
  endtask

  function automatic logic [2:0] cti_of(input int beat, input int n);
    if (n == 1)      return 3'b000;
    if (beat == n-1) return 3'b111;
    return 3'b010;
  endfunction

  // One Wishbone cycle of n beats; leaves one idle cycle after dropping cyc.
  task automatic m_burst(input int m, input logic [31:0] base, input int n, input logic we);
    int beat = 0;
    int cycles = 0;
    drive(m, 1'b1, base, we, cti_of(0, n));
    while (beat < n && cycles < 200) begin
      @(negedge sys_clk);
      cycles++;
      if ((m == 0) ? m0_ack : m1_ack) begin
        beat++;
        @(posedge sys_clk); #1;
        if (beat < n) drive(m, 1'b1, base + 32'(4*beat), we, cti_of(beat, n));
      end
    end
    if (beat < n) chk($sformatf("burst_timeout_m%0d", m), 64'(beat), 64'(n));
    drive(m, 1'b0, 32'h0, 1'b0, 3'b000);
    @(posedge sys_clk); #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    drive(0, 1'b0, 32'h0, 1'b0, 3'b000);
    drive(1, 1'b0, 32'h0, 1'b0, 3'b000);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    log_q.delete(); trace_q.delete();
    ack0_cnt = 0; ack1_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_bad;
    int first1, last1, zeros;

    // Reset with both masters requesting.
    sys_rst = 1'b1; ack_en = 1'b1; s_err = 1'b0; s_rty = 1'b0;
    drive(0, 1'b1, 32'h40, 1'b0, 3'b000);
    drive(1, 1'b1, 32'h80, 1'b0, 3'b000);
    repeat (3) @(negedge sys_clk);
    chk("rst_gnt",    gnt,    2'b00);
    chk("rst_s_cyc",  s_cyc,  1'b0);
    chk("rst_s_stb",  s_stb,  1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rel_gnt",   gnt,   2'b01);
    chk("rel_s_cyc", s_cyc, 1'b1);
    chk("rel_s_adr", s_adr, 32'h40);
    s_err = 1'b1;
    #1;
    chk("err_m0",    m0_err,    1'b1);
    chk("err_m1",    m1_err,    1'b0);
    chk("dat_sm_m0", m0_dat_sm, 32'hA5A5_1234);
    chk("dat_sm_m1", m1_dat_sm, 32'hA5A5_1234);
    s_err = 1'b0;

    // Single master: four single writes from M1.
    do_reset();
    for (int i = 0; i < 4; i++) m_burst(1, 32'h100 + 32'(4*i), 1, 1'b1);
    chk("single_count", log_q.size(), 4);
    foreach (log_q[i]) begin
      chk($sformatf("single_adr%0d", i), log_q[i].adr, 32'h100 + 32'(4*i));
      chk($sformatf("single_we%0d", i),  log_q[i].we,  1'b1);
      chk($sformatf("single_gnt%0d", i), log_q[i].g,   2'b10);
    end
    chk("single_ack0", ack0_cnt, 0);
    chk("single_ack1", ack1_cnt, 4);

    // Tie from reset: M0 first, one cycle of s_cyc low at handover.
    do_reset();
    fork
      m_burst(0, 32'h200, 4, 1'b1);
      m_burst(1, 32'h300, 4, 1'b1);
    join
    build_segs();
    chk("tie_segs", seg_g.size(), 2);
    if (seg_g.size() == 2) begin
      chk("tie_g0",  seg_g[0],  2'b01);
      chk("tie_n0",  seg_n[0],  4);
      chk("tie_g1",  seg_g[1],  2'b10);
      chk("tie_n1",  seg_n[1],  4);
      chk("tie_a1",  seg_a0[1], 32'h300);
    end
    first1 = -1; last1 = -1; zeros = 0;
    foreach (trace_q[i]) if (trace_q[i]) begin
      if (first1 < 0) first1 = i;
      last1 = i;
    end
    for (int i = 0; i < trace_q.size(); i++)
      if (i > first1 && i < last1 && !trace_q[i]) zeros++;
    chk("tie_gap", zeros, 1);

    // Round robin: both masters issue two 8-beat bursts back to back.
    do_reset();
    fork
      begin
        m_burst(0, 32'h1000, 8, 1'b0);
        m_burst(0, 32'h1100, 8, 1'b0);
      end
      begin
        m_burst(1, 32'h2000, 8, 1'b0);
        m_burst(1, 32'h2100, 8, 1'b0);
      end
    join
    build_segs();
    chk("rr_segs", seg_g.size(), 4);
    if (seg_g.size() == 4) begin
      chk("rr_g0", seg_g[0], 2'b01); chk("rr_a0", seg_a0[0], 32'h1000); chk("rr_n0", seg_n[0], 8);
      chk("rr_g1", seg_g[1], 2'b10); chk("rr_a1", seg_a0[1], 32'h2000); chk("rr_n1", seg_n[1], 8);
      chk("rr_g2", seg_g[2], 2'b01); chk("rr_a2", seg_a0[2], 32'h1100); chk("rr_n2", seg_n[2], 8);
      chk("rr_g3", seg_g[3], 2'b10); chk("rr_a3", seg_a0[3], 32'h2100); chk("rr_n3", seg_n[3], 8);
    end
    if (log_q.size() >= 8) begin
      chk("rr_cti_last",  log_q[7].cti, 3'b111);
      chk("rr_cti_first", log_q[0].cti, 3'b010);
      chk("rr_adr_last",  log_q[7].adr, 32'h101C);
    end

    // Hold: M0 stalled 20 cycles while M1 waits.
    do_reset();
    ack_en = 1'b0;
    hold_bad = 0;
    fork
      m_burst(0, 32'h400, 1, 1'b0);
      m_burst(1, 32'h500, 1, 1'b0);
      begin
        @(posedge sys_clk);
        repeat (20) begin
          @(negedge sys_clk);
          if (gnt !== 2'b01 || m1_ack !== 1'b0) hold_bad++;
        end
        #2 ack_en = 1'b1;
      end
    join
    chk("hold_bad",  hold_bad, 0);
    chk("hold_ack0", ack0_cnt, 1);
    chk("hold_ack1", ack1_cnt, 1);
    chk("hold_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("hold_first",  log_q[0].g, 2'b01);
      chk("hold_second", log_q[1].g, 2'b10);
    end

    // Mid-burst reset on beat 3 of an M0 burst.
    do_reset();
    drive(0, 1'b1, 32'h600, 1'b0, 3'b010);
    @(negedge sys_clk);
    for (int i = 1; i < 3; i++) begin
      @(posedge sys_clk); #1;
      drive(0, 1'b1, 32'h600 + 32'(4*i), 1'b0, 3'b010);
    end
    @(negedge sys_clk);
    chk("mb_pre_cyc", s_cyc, 1'b1);
    chk("mb_pre_adr", s_adr, 32'h608);
    #2 sys_rst = 1'b1;
    #1;
    chk("mb_rst_cyc",  s_cyc,  1'b0);
    chk("mb_rst_stb",  s_stb,  1'b0);
    chk("mb_rst_gnt",  gnt,    2'b00);
    chk("mb_rst_ack0", m0_ack, 1'b0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("mb_regnt", gnt,   2'b01);
    chk("mb_recyc", s_cyc, 1'b1);
    drive(0, 1'b0, 32'h0, 1'b0, 3'b000);
    repeat (2) @(negedge sys_clk);
    chk("mb_idle", gnt, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
